// File: rtl/hazard_scoreboard.sv
// Self-tracking hazard/forwarding scoreboard beside the ID stage.
// Optional perf counters: define HAZARD_PERF_CNT_EN.

module hazard_match #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2
) (
    input  logic [REG_AW-1:0]            src,
    input  logic                         use_src,
    input  logic [DEPTH:1]               slot_v,
    input  logic [DEPTH:1][REG_AW-1:0]   slot_rd,
    input  logic [DEPTH:1]               slot_ld,
    output logic [2:0]                   fwd,
    output logic                         hazard
);
    localparam logic [2:0] LL = 3'(LOAD_LAT);

    logic       hit;
    logic       hit_ld;
    logic [2:0] hit_k;

    // Scan oldest to youngest so the nearest slot overwrites any older match.
    always_comb begin
        hit    = 1'b0;
        hit_ld = 1'b0;
        hit_k  = 3'd0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (use_src && (src != '0) && slot_v[k] && (slot_rd[k] == src)) begin
                hit    = 1'b1;
                hit_ld = slot_ld[k];
                hit_k  = 3'(k);
            end
        end
    end

    assign hazard = hit & hit_ld & (hit_k < LL);
    assign fwd    = (hit && !hazard) ? hit_k : 3'd0;
endmodule

module hazard_scoreboard #(
    parameter int REG_AW      = 5,
    parameter int DEPTH       = 3,
    parameter int LOAD_LAT    = 2,
    parameter int FLUSH_SLOTS = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              branch_taken,
    input  logic              jump_id,
    output logic              stall,
    output logic              id_ex_bubble,
    output logic              if_flush,
    output logic [2:0]        forward_a,
    output logic [2:0]        forward_b,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);
    logic [DEPTH:1]             slot_v;
    logic [DEPTH:1]             slot_ld;
    logic [DEPTH:1][REG_AW-1:0] slot_rd;

    logic [1:0][REG_AW-1:0] op_src;
    logic [1:0]             op_use;
    logic [1:0]             op_hz;
    logic [1:0][2:0]        op_fwd;

    logic       raw_stall;
    logic       redirect;
    logic       new_v;
    logic [1:0] flush_cnt;

    assign op_src = {id_rt, id_rs};
    assign op_use = {id_use_rt, id_use_rs};

    for (genvar i = 0; i < 2; i++) begin : g_op
        hazard_match #(
            .REG_AW   (REG_AW),
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT)
        ) u_match (
            .src     (op_src[i]),
            .use_src (op_use[i]),
            .slot_v  (slot_v),
            .slot_rd (slot_rd),
            .slot_ld (slot_ld),
            .fwd     (op_fwd[i]),
            .hazard  (op_hz[i])
        );
    end

    assign forward_a    = op_fwd[0];
    assign forward_b    = op_fwd[1];
    assign raw_stall    = id_valid & (|op_hz);
    assign id_ex_bubble = raw_stall | branch_taken;
    assign stall        = raw_stall & ~branch_taken;
    // A jump held by a load-use stall is re-presented later, so it is not an event yet.
    assign redirect     = branch_taken | (jump_id & ~raw_stall);
    assign if_flush     = redirect | (flush_cnt != 2'd0);
    assign new_v        = id_valid & id_reg_write & (id_rd != '0) & ~id_ex_bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v    <= '0;
            slot_ld   <= '0;
            slot_rd   <= '0;
            flush_cnt <= 2'd0;
        end else begin
            slot_v  <= {slot_v[DEPTH-1:1], new_v};
            slot_ld <= {slot_ld[DEPTH-1:1], id_is_load};
            slot_rd <= {slot_rd[DEPTH-1:1], id_rd};
            if (redirect)
                flush_cnt <= 2'(FLUSH_SLOTS - 1);
            else if (flush_cnt != 2'd0)
                flush_cnt <= flush_cnt - 2'd1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
            if (redirect && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: u0 (LOAD_LAT=2, FLUSH_SLOTS=2, CNT_W=4) and u1 (LOAD_LAT=3, FLUSH_SLOTS=1) share stimulus.
module tb_hazard_scoreboard;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_is_load;
    logic       branch_taken, jump_id;
    logic [4:0] id_rs, id_rt, id_rd;

    logic        u0_stall, u0_bubble, u0_flush;
    logic [2:0]  u0_fa, u0_fb;
    logic [3:0]  u0_sc, u0_fc;
    logic        u1_stall, u1_bubble, u1_flush;
    logic [2:0]  u1_fa, u1_fb;
    logic [15:0] u1_sc, u1_fc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .LOAD_LAT(2), .FLUSH_SLOTS(2), .CNT_W(4)) u0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .branch_taken(branch_taken), .jump_id(jump_id),
        .stall(u0_stall), .id_ex_bubble(u0_bubble), .if_flush(u0_flush),
        .forward_a(u0_fa), .forward_b(u0_fb), .stall_count(u0_sc), .flush_count(u0_fc));

    hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .LOAD_LAT(3), .FLUSH_SLOTS(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .branch_taken(branch_taken), .jump_id(jump_id),
        .stall(u1_stall), .id_ex_bubble(u1_bubble), .if_flush(u1_flush),
        .forward_a(u1_fa), .forward_b(u1_fb), .stall_count(u1_sc), .flush_count(u1_fc));

    // One ID cycle: inputs change at the falling edge, outputs are checked 1ns later.
    task automatic drive(input logic v, input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                         input logic urt, input logic [4:0] rd, input logic rw, input logic ld,
                         input logic br, input logic jp);
        @(negedge clk);
        id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_rd = rd; id_reg_write = rw; id_is_load = ld; branch_taken = br; jump_id = jp;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        checks++; if (u0_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0d exp 0", u0_stall); end
        checks++; if (u0_fa !== 3'd0 || u0_fb !== 3'd0) begin errors++; $display("FAIL rst_fwd got %0d/%0d exp 0/0", u0_fa, u0_fb); end
        checks++; if (u0_flush !== 1'b0 || u0_bubble !== 1'b0) begin errors++; $display("FAIL rst_flush_bubble got %0d/%0d exp 0/0", u0_flush, u0_bubble); end
        checks++; if (u0_sc !== 4'd0 || u0_fc !== 4'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", u0_sc, u0_fc); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_forward();
        do_reset();
        drive(1, 1, 0, 2, 0, 3, 1, 0, 0, 0);          // add r3
        checks++; if (u0_fa !== 3'd0) begin errors++; $display("FAIL fwd_empty got %0d exp 0", u0_fa); end
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);          // reader of r3
        checks++; if (u0_fa !== 3'd1 || u0_stall !== 1'b0) begin errors++; $display("FAIL fwd_ex got %0d stall %0d exp 1 stall 0", u0_fa, u0_stall); end
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (u0_fa !== 3'd2) begin errors++; $display("FAIL fwd_mem got %0d exp 2", u0_fa); end
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (u0_fa !== 3'd3) begin errors++; $display("FAIL fwd_wb got %0d exp 3", u0_fa); end
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (u0_fa !== 3'd0) begin errors++; $display("FAIL fwd_drained got %0d exp 0", u0_fa); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);          // lw r5
        drive(1, 1, 0, 5, 1, 6, 1, 0, 0, 0);          // add r6 reads r5 as rt
        checks++; if (u0_stall !== 1'b1 || u0_bubble !== 1'b1) begin errors++; $display("FAIL ld_stall got %0d/%0d exp 1/1", u0_stall, u0_bubble); end
        checks++; if (u0_fb !== 3'd0) begin errors++; $display("FAIL ld_fwd_hz got %0d exp 0", u0_fb); end
        drive(1, 1, 0, 5, 1, 6, 1, 0, 0, 0);
        checks++; if (u0_stall !== 1'b0 || u0_fb !== 3'd2) begin errors++; $display("FAIL ld_release got stall %0d fwd %0d exp 0 2", u0_stall, u0_fb); end
        checks++; if (u0_sc !== (CNT_ON ? 4'd1 : 4'd0)) begin errors++; $display("FAIL ld_stall_cnt got %0d exp %0d", u0_sc, CNT_ON ? 1 : 0); end
        checks++; if (u1_stall !== 1'b1) begin errors++; $display("FAIL ll3_second_stall got %0d exp 1", u1_stall); end
        drive(1, 1, 0, 5, 1, 6, 1, 0, 0, 0);
        checks++; if (u1_stall !== 1'b0 || u1_fb !== 3'd3) begin errors++; $display("FAIL ll3_release got stall %0d fwd %0d exp 0 3", u1_stall, u1_fb); end
        checks++; if (u1_sc !== (CNT_ON ? 16'd2 : 16'd0)) begin errors++; $display("FAIL ll3_stall_cnt got %0d exp %0d", u1_sc, CNT_ON ? 2 : 0); end
        checks++; if (u0_fb !== 3'd3) begin errors++; $display("FAIL ld_fwd_wb got %0d exp 3", u0_fb); end
    endtask

    task automatic test_nearest();
        do_reset();
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);          // add r4
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);          // add r4 again
        drive(1, 4, 1, 4, 1, 0, 0, 0, 0, 0);
        checks++; if (u0_fa !== 3'd1 || u0_fb !== 3'd1) begin errors++; $display("FAIL nearest got %0d/%0d exp 1/1", u0_fa, u0_fb); end
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);          // load to r0
        drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        checks++; if (u0_fa !== 3'd0 || u0_fb !== 3'd0 || u0_stall !== 1'b0) begin errors++; $display("FAIL r0_match got %0d/%0d stall %0d exp 0/0 0", u0_fa, u0_fb, u0_stall); end
    endtask

    task automatic test_branch_stall();
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);          // lw r5
        drive(1, 0, 0, 5, 1, 6, 1, 0, 1, 0);          // use r5 + branch taken
        checks++; if (u0_stall !== 1'b0 || u0_bubble !== 1'b1 || u0_flush !== 1'b1) begin errors++; $display("FAIL br_stall got %0d/%0d/%0d exp 0/1/1", u0_stall, u0_bubble, u0_flush); end
        idle();
        checks++; if (u0_flush !== 1'b1 || u1_flush !== 1'b0) begin errors++; $display("FAIL br_flush_len got %0d/%0d exp 1/0", u0_flush, u1_flush); end
        checks++; if (u0_fc !== (CNT_ON ? 4'd1 : 4'd0)) begin errors++; $display("FAIL br_flush_cnt got %0d exp %0d", u0_fc, CNT_ON ? 1 : 0); end
        idle();
        checks++; if (u0_flush !== 1'b0) begin errors++; $display("FAIL br_flush_end got %0d exp 0", u0_flush); end
    endtask

    task automatic test_jump_stall();
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);          // lw r5
        drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 1);          // jump that also reads r5
        checks++; if (u0_stall !== 1'b1 || u0_flush !== 1'b0) begin errors++; $display("FAIL jp_hold got stall %0d flush %0d exp 1 0", u0_stall, u0_flush); end
        drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 1);
        checks++; if (u0_stall !== 1'b0 || u0_flush !== 1'b1) begin errors++; $display("FAIL jp_go got stall %0d flush %0d exp 0 1", u0_stall, u0_flush); end
        checks++; if (u0_fc !== 4'd0) begin errors++; $display("FAIL jp_gated_cnt got %0d exp 0", u0_fc); end
        idle();
        checks++; if (u0_flush !== 1'b1 || u0_fc !== (CNT_ON ? 4'd1 : 4'd0)) begin errors++; $display("FAIL jp_tail got flush %0d cnt %0d exp 1 %0d", u0_flush, u0_fc, CNT_ON ? 1 : 0); end
    endtask

    task automatic test_saturation_and_reset();
        do_reset();
        // Load reading its own dest r5: u0 stalls every 2nd cycle, u1 two of every 3.
        for (int i = 0; i < 41; i++) drive(1, 0, 0, 5, 1, 5, 1, 1, 0, 0);
        idle();
        checks++; if (u0_sc !== (CNT_ON ? 4'd15 : 4'd0)) begin errors++; $display("FAIL sat_cnt got %0d exp %0d", u0_sc, CNT_ON ? 15 : 0); end
        checks++; if (u1_sc !== (CNT_ON ? 16'd27 : 16'd0)) begin errors++; $display("FAIL ll3_cnt got %0d exp %0d", u1_sc, CNT_ON ? 27 : 0); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);          // jump
        idle();
        checks++; if (u0_flush !== 1'b1) begin errors++; $display("FAIL mid_flush got %0d exp 1", u0_flush); end
        rst_n = 1'b0;
        #1;
        checks++; if (u0_flush !== 1'b0) begin errors++; $display("FAIL async_rst_flush got %0d exp 0", u0_flush); end
        checks++; if (u0_sc !== 4'd0 || u0_fc !== 4'd0 || u1_sc !== 16'd0) begin errors++; $display("FAIL async_rst_cnt got %0d/%0d/%0d exp 0/0/0", u0_sc, u0_fc, u1_sc); end
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        id_valid = 0; id_rs = 0; id_use_rs = 0; id_rt = 0; id_use_rt = 0;
        id_rd = 0; id_reg_write = 0; id_is_load = 0; branch_taken = 0; jump_id = 0;
        test_reset();
        test_forward();
        test_load_use();
        test_nearest();
        test_branch_stall();
        test_jump_stall();
        test_saturation_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
